// File: rtl/hvac_zone_ctrl.sv
// hvac_zone_ctrl: per-zone heat/cool hysteresis FSM with min-run/min-off timing and sticky range alarm
module hvac_zone_ctrl #(
  parameter int N_ZONES = 4,
  parameter int TEMP_W  = 12,
  parameter int HYST    = 8,
  parameter int MIN_RUN = 64,
  parameter int MIN_OFF = 32,
  parameter int T_MIN   = -640,
  parameter int T_MAX   = 1600
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_ZONES*TEMP_W-1:0]   setpoint,
  input  logic [N_ZONES*TEMP_W-1:0]   temp,
  input  logic [N_ZONES-1:0]          sample_valid,
  input  logic [1:0]                  mode,
  input  logic [N_ZONES-1:0]          alarm_clr,
  output logic [N_ZONES-1:0]          heat,
  output logic [N_ZONES-1:0]          cool,
  output logic [N_ZONES-1:0]          idle,
  output logic [N_ZONES-1:0]          lockout,
  output logic [N_ZONES-1:0]          alarm
);
  localparam int MAXC = MIN_RUN > MIN_OFF ? MIN_RUN : MIN_OFF;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RUN_END = CW'(MIN_RUN);
  localparam logic [CW-1:0] OFF_END = CW'(MIN_OFF - 1);
  localparam logic signed [TEMP_W:0] HP = (TEMP_W+1)'(HYST);
  localparam logic signed [TEMP_W:0] HN = -HP;
  localparam logic signed [TEMP_W:0] LO = (TEMP_W+1)'(T_MIN);
  localparam logic signed [TEMP_W:0] HI = (TEMP_W+1)'(T_MAX);
  typedef enum logic [1:0] {IDLE, HEAT, COOL, OFFDLY} state_t;
  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    state_t st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic signed [TEMP_W:0] t, s, err;
    logic v, run_done, al;
    // one extra bit keeps temp - setpoint exact for any input pair
    assign t = {temp[z*TEMP_W+TEMP_W-1], temp[z*TEMP_W +: TEMP_W]};
    assign s = {setpoint[z*TEMP_W+TEMP_W-1], setpoint[z*TEMP_W +: TEMP_W]};
    assign err = t - s;
    assign v = sample_valid[z];
    assign run_done = cnt == RUN_END;
    always_comb begin
      st_n = st;
      case (st)
        IDLE:    st_n = (v && err <= HN && mode[0]) ? HEAT : (v && err >= HP && mode[1]) ? COOL : IDLE;
        HEAT:    st_n = (run_done && ((v && !err[TEMP_W]) || !mode[0])) ? OFFDLY : HEAT;
        COOL:    st_n = (run_done && ((v && (err[TEMP_W] || err == '0)) || !mode[1])) ? OFFDLY : COOL;
        OFFDLY:  st_n = (cnt == OFF_END) ? IDLE : OFFDLY;
        default: st_n = IDLE;
      endcase
      // shared counter: run time in HEAT/COOL (saturating), off time in OFFDLY
      cnt_n = (st_n != st || st == IDLE) ? '0 : (run_done && st != OFFDLY) ? cnt : cnt + CW'(1);
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        st  <= IDLE;
        cnt <= '0;
        al  <= 1'b0;
      end else begin
        st  <= st_n;
        cnt <= cnt_n;
        al  <= (v && (t < LO || t > HI)) || (al && !alarm_clr[z]);
      end
    end
    assign heat[z]    = st == HEAT;
    assign cool[z]    = st == COOL;
    assign idle[z]    = st == IDLE;
    assign lockout[z] = st == OFFDLY;
    assign alarm[z]   = al;
  end
endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// tb_hvac_zone_ctrl: table-driven single-step vectors plus multi-cycle timing sequences
module tb_hvac_zone_ctrl;
  localparam logic [3:0] H = 4'b1000, C = 4'b0100, I = 4'b0010, L = 4'b0001;
  localparam logic [1:0] OFF = 2'd0, HO = 2'd1, CO = 2'd2, AU = 2'd3;
  logic clk = 1'b0, reset = 1'b0;
  logic signed [11:0] t0 = 12'sd320, t1 = 12'sd320;
  logic signed [11:0] sp0 = 12'sd320, sp1 = 12'sd320;
  logic [23:0] setpoint, temp;
  logic [1:0] sample_valid = '0, mode = AU, alarm_clr = '0;
  logic [1:0] heat, cool, idle, lockout, alarm;
  int tests = 0, fails = 0;
  typedef struct {
    logic rst;
    logic [1:0] md, vld, clr;
    logic signed [11:0] a, b;
    logic [3:0] z0, z1;
    logic [1:0] al;
  } vec_t;
  vec_t tbl[17];
  assign setpoint = {sp1, sp0};
  assign temp = {t1, t0};
  always #5 clk = ~clk;
  hvac_zone_ctrl #(.N_ZONES(2), .TEMP_W(12), .HYST(4), .MIN_RUN(8), .MIN_OFF(6),
                   .T_MIN(-640), .T_MAX(1600)) dut (
    .clk(clk), .reset(reset), .setpoint(setpoint), .temp(temp),
    .sample_valid(sample_valid), .mode(mode), .alarm_clr(alarm_clr),
    .heat(heat), .cool(cool), .idle(idle), .lockout(lockout), .alarm(alarm));
  function automatic vec_t mk(logic r, logic [1:0] md, logic [1:0] vld, logic [1:0] clr,
                              int a, int b, logic [3:0] z0, logic [3:0] z1, logic [1:0] al);
    vec_t x;
    x.rst = r; x.md = md; x.vld = vld; x.clr = clr;
    x.a = 12'(a); x.b = 12'(b); x.z0 = z0; x.z1 = z1; x.al = al;
    return x;
  endfunction
  task automatic apply(logic r, logic [1:0] md, logic [1:0] vld, logic [1:0] clr, int a, int b);
    reset = r; mode = md; sample_valid = vld; alarm_clr = clr;
    t0 = 12'(a); t1 = 12'(b);
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [3:0] e0, logic [3:0] e1, logic [1:0] ea);
    logic [9:0] got, exp;
    got = {heat, cool, idle, lockout, alarm};
    exp = {e1[3], e0[3], e1[2], e0[2], e1[1], e0[1], e1[0], e0[0], ea};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got heat/cool/idle/lockout/alarm=%b expected %b", nm, got, exp);
    end
  endtask
  initial begin
    tbl[0]  = mk(1, AU, 2'b00, 0, 320, 320, I, I, 2'b00);
    tbl[1]  = mk(0, AU, 2'b11, 0, 310, 321, H, I, 2'b00);
    tbl[2]  = mk(1, AU, 2'b00, 0, 320, 320, I, I, 2'b00);
    tbl[3]  = mk(0, AU, 2'b11, 0, 324, 323, C, I, 2'b00);
    tbl[4]  = mk(1, AU, 2'b00, 0, 320, 320, I, I, 2'b00);
    tbl[5]  = mk(0, AU, 2'b11, 0, 316, 317, H, I, 2'b00);
    tbl[6]  = mk(1, AU, 2'b00, 0, 320, 320, I, I, 2'b00);
    tbl[7]  = mk(0, HO, 2'b11, 0, 300, 340, H, I, 2'b00);
    tbl[8]  = mk(1, AU, 2'b00, 0, 320, 320, I, I, 2'b00);
    tbl[9]  = mk(0, CO, 2'b11, 0, 300, 340, I, C, 2'b00);
    tbl[10] = mk(1, AU, 2'b00, 0, 320, 320, I, I, 2'b00);
    tbl[11] = mk(0, OFF, 2'b11, 0, 300, 340, I, I, 2'b00);
    tbl[12] = mk(0, AU, 2'b00, 0, 300, 340, I, I, 2'b00);
    tbl[13] = mk(1, AU, 2'b11, 0, 300, 340, I, I, 2'b00);
    tbl[14] = mk(0, AU, 2'b11, 0, 1601, -641, C, H, 2'b11);
    tbl[15] = mk(1, AU, 2'b00, 0, 320, 320, I, I, 2'b00);
    tbl[16] = mk(0, AU, 2'b11, 0, 1600, -640, C, H, 2'b00);
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].rst, tbl[i].md, tbl[i].vld, tbl[i].clr, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d", i), tbl[i].z0, tbl[i].z1, tbl[i].al);
    end
    // heat min-run, early exit ignored, lockout length, samples ignored in lockout
    apply(1, AU, 0, 0, 320, 320);
    apply(0, AU, 2'b01, 0, 310, 320);
    chk("heat_enter", H, I, 0);
    repeat (3) apply(0, AU, 0, 0, 320, 320);
    apply(0, AU, 2'b01, 0, 325, 320);
    chk("heat_early_exit_ignored", H, I, 0);
    repeat (4) apply(0, AU, 0, 0, 320, 320);
    chk("heat_at_min_run", H, I, 0);
    repeat (2) apply(0, AU, 0, 0, 320, 320);
    chk("heat_saturated_hold", H, I, 0);
    apply(0, AU, 2'b01, 0, 325, 320);
    chk("heat_exit_lockout", L, I, 0);
    for (int k = 2; k <= 6; k++) begin
      apply(0, AU, 2'b01, 0, 310, 320);
      chk($sformatf("lockout_clk%0d", k), L, I, 0);
    end
    apply(0, AU, 2'b01, 0, 310, 320);
    chk("lockout_to_idle", I, I, 0);
    apply(0, AU, 2'b01, 0, 310, 320);
    chk("idle_reheat", H, I, 0);
    // cool held through mode OFF until min-run, then lockout ignoring mode
    apply(1, AU, 0, 0, 320, 320);
    apply(0, AU, 2'b01, 0, 324, 320);
    chk("cool_enter", C, I, 0);
    repeat (2) apply(0, AU, 0, 0, 320, 320);
    apply(0, OFF, 0, 0, 320, 320);
    chk("cool_mode_off_early", C, I, 0);
    for (int k = 4; k <= 8; k++) begin
      apply(0, OFF, 0, 0, 320, 320);
      chk($sformatf("cool_hold_cnt%0d", k), C, I, 0);
    end
    apply(0, OFF, 0, 0, 320, 320);
    chk("cool_mode_exit", L, I, 0);
    repeat (5) apply(0, HO, 2'b01, 0, 300, 320);
    chk("lockout_ignores_mode", L, I, 0);
    apply(0, HO, 2'b01, 0, 300, 320);
    chk("lockout_end", I, I, 0);
    apply(0, HO, 2'b01, 0, 300, 320);
    chk("heat_only_enter", H, I, 0);
    // cool exit via samples: err>0 holds, err=0 exits
    apply(1, AU, 0, 0, 320, 320);
    apply(0, AU, 2'b01, 0, 324, 320);
    repeat (8) apply(0, AU, 0, 0, 320, 320);
    apply(0, AU, 2'b01, 0, 321, 320);
    chk("cool_err_pos_hold", C, I, 0);
    apply(0, AU, 2'b01, 0, 320, 320);
    chk("cool_err_zero_exit", L, I, 0);
    // sticky alarm, set beats clear
    apply(1, OFF, 0, 0, 320, 320);
    apply(0, OFF, 2'b01, 0, 1601, 320);
    chk("alarm_set", I, I, 2'b01);
    apply(0, OFF, 0, 0, 320, 320);
    chk("alarm_sticky", I, I, 2'b01);
    apply(0, OFF, 2'b01, 2'b01, 1601, 320);
    chk("alarm_set_wins", I, I, 2'b01);
    apply(0, OFF, 0, 2'b01, 320, 320);
    chk("alarm_clear", I, I, 2'b00);
    apply(0, OFF, 2'b10, 0, 320, -700);
    chk("alarm_zone1_only", I, I, 2'b10);
    // reset during lockout drops protection immediately
    apply(1, AU, 0, 0, 320, 320);
    apply(0, AU, 2'b01, 0, 310, 320);
    repeat (8) apply(0, AU, 0, 0, 320, 320);
    apply(0, AU, 2'b01, 0, 325, 320);
    chk("rst_seq_lockout", L, I, 0);
    repeat (2) apply(0, AU, 0, 0, 320, 320);
    chk("rst_seq_lockout3", L, I, 0);
    apply(1, AU, 2'b01, 0, 310, 320);
    chk("rst_in_lockout", I, I, 0);
    apply(0, AU, 2'b01, 0, 310, 320);
    chk("heat_after_rst", H, I, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hvac_zone_ctrl.md
HVAC_ZONE_CTRL -- requirements
Module: hvac_zone_ctrl

Interface
REQ-001 SHALL have parameter N_ZONES, default 4, number of independent zones.
REQ-002 SHALL have parameter TEMP_W, default 12, signed two's-complement temperature width (LSB = 1/16 degree).
REQ-003 SHALL have parameter HYST, default 8, hysteresis band in LSBs, legal range 1..2^(TEMP_W-2).
REQ-004 SHALL have parameter MIN_RUN, default 64, minimum clocks in HEAT/COOL before exit, legal range 1 or more.
REQ-005 SHALL have parameter MIN_OFF, default 32, clocks in OFFDLY before re-entry to IDLE, legal range 1 or more.
REQ-006 SHALL have parameters T_MIN and T_MAX, defaults -640 and 1600, alarm limits in LSBs.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 setpoint  input  N_ZONES*TEMP_W  packed per-zone setpoints, zone i at bits [i*TEMP_W +: TEMP_W].
REQ-010 temp  input  N_ZONES*TEMP_W  packed per-zone measured temperatures, same packing.
REQ-011 sample_valid  input  N_ZONES  per-zone strobe; temp[i]/setpoint[i] evaluated only when high.
REQ-012 mode  input  2  00 OFF, 01 HEAT_ONLY, 10 COOL_ONLY, 11 AUTO; shared by all zones.
REQ-013 alarm_clr  input  N_ZONES  per-zone clear of sticky alarm.
REQ-014 heat, cool, idle, lockout  output  N_ZONES each  per-zone registered state decode.
REQ-015 alarm  output  N_ZONES  per-zone sticky out-of-range flag.

Function
REQ-016 Each zone SHALL run an independent FSM with states IDLE, HEAT, COOL, OFFDLY.
REQ-017 Outputs SHALL decode state: heat=HEAT, cool=COOL, idle=IDLE, lockout=OFFDLY; exactly one high per zone at all times.
REQ-018 err SHALL be computed as temp-setpoint at TEMP_W+1 bits signed; no wrap, no saturation.
REQ-019 IDLE->HEAT when sample_valid, err <= -HYST, mode is HEAT_ONLY or AUTO.
REQ-020 IDLE->COOL when sample_valid, err >= +HYST, mode is COOL_ONLY or AUTO.
REQ-021 IDLE SHALL hold when sample_valid is low, when err lies strictly inside (-HYST, +HYST), or when mode forbids the required direction.
REQ-022 Per-zone run counter SHALL clear on entry to HEAT/COOL, increment each clock, and saturate at MIN_RUN.
REQ-023 HEAT->OFFDLY when run counter = MIN_RUN and either (sample_valid and err >= 0) or mode is OFF/COOL_ONLY.
REQ-024 COOL->OFFDLY when run counter = MIN_RUN and either (sample_valid and err <= 0) or mode is OFF/HEAT_ONLY.
REQ-025 An exit condition met before MIN_RUN SHALL be ignored, not latched; the zone re-evaluates on later samples once MIN_RUN is reached.
REQ-026 Mode exit conditions in REQ-023/REQ-024 are level conditions, evaluated every clock, and independent of sample_valid.
REQ-027 OFFDLY SHALL count MIN_OFF clocks (counter cleared on entry) and then go to IDLE, ignoring samples and mode.
REQ-028 HEAT->COOL and COOL->HEAT direct transitions SHALL never occur.
REQ-029 Transition latency: the condition is sampled at edge k; the new state and outputs are visible after edge k.
REQ-030 alarm[i] SHALL set when sample_valid[i] and (temp < T_MIN or temp > T_MAX), and hold until alarm_clr[i] or reset.
REQ-031 Set SHALL win over a simultaneous alarm_clr; alarm SHALL NOT affect FSM behaviour.
REQ-032 Zones SHALL share no state except mode; simultaneous events in different zones are handled independently in the same cycle.

Reset
REQ-033 While reset is high at a clock edge, every zone SHALL enter IDLE, counters and alarm SHALL clear, and outputs SHALL read idle=1, heat=cool=lockout=alarm=0 after that edge.
REQ-034 Reset mid-HEAT/COOL/OFFDLY SHALL abandon the MIN_RUN/MIN_OFF protection and go to IDLE.
REQ-035 Reset SHALL take priority over all inputs in the same cycle.

Verification (N_ZONES=2, TEMP_W=12, HYST=4, MIN_RUN=8, MIN_OFF=6, T_MIN=-640, T_MAX=1600)
REQ-036 AUTO, zone0 setpoint=320, temp=310, sample -> heat[0]=1 next cycle; zone1 at temp=321 stays idle.
REQ-037 In HEAT, sample temp=325 at run count 3 -> heat holds; resample at count 8 -> lockout for exactly 6 clocks, then idle.
REQ-038 AUTO, setpoint=320, temp=324 -> cool; temp=323 from IDLE -> stays idle (boundary +HYST/-HYST inclusive).
REQ-039 In COOL, mode switched to OFF at run count 2 -> cool holds until count 8, then lockout; HEAT_ONLY with temp=300 from IDLE -> heat.
REQ-040 temp=1601 sample -> alarm=1 sticky; alarm_clr together with another bad sample -> stays 1; alarm_clr alone -> 0.
REQ-041 Reset asserted during lockout at clock 3 -> idle=1, lockout=0 next cycle; a valid heat demand immediately after -> heat with no MIN_OFF wait.
